// File: rtl/toast_arb_pkg.sv
// Shared types and helpers for the fetch/data memory arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package toast_arb_pkg;

  // Owner of the single in-flight read; selects which port sees rvalid.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Starve counter width; covers the full legal STARVE_MAX range 1..15.
  localparam int STARVE_CNT_W = 4;

  // Byte-enable width for a given data width.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/toast_arb_starve_ctr.sv
// Saturating count of consecutive denied fetch-request cycles.
// Latency: at_max reflects the registered count (updates one cycle after inc).
// Backpressure: none; clr takes priority over inc.
module toast_arb_starve_ctr
  import toast_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STARVE_CNT_W-1:0] MAX_CNT = STARVE_CNT_W'(MAX);

  logic [STARVE_CNT_W-1:0] cnt;

  // Count denied cycles, hold at MAX, clear when fetch wins or stops asking.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_CNT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX_CNT);

endmodule

// File: rtl/toast_mem_arbiter.sv
// Shares one single-port sync memory between fetch (I) and load/store (D) ports.
// Latency: grant 0 cycles (combinational); read data valid 1 cycle after grant.
// Backpressure: ungranted port sees gnt=0 and Core_stall=1; it must hold its request.
module toast_mem_arbiter
  import toast_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        I_req,
  input  logic [ADDR_W-1:0]           I_addr,
  output logic                        I_gnt,
  output logic                        I_rvalid,
  output logic [DATA_W-1:0]           I_rdata,
  input  logic                        D_req,
  input  logic                        D_we,
  input  logic [be_width(DATA_W)-1:0] D_be,
  input  logic [ADDR_W-1:0]           D_addr,
  input  logic [DATA_W-1:0]           D_wdata,
  output logic                        D_gnt,
  output logic                        D_rvalid,
  output logic [DATA_W-1:0]           D_rdata,
  output logic                        mem_en,
  output logic [be_width(DATA_W)-1:0] mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        Core_stall
);

  localparam int BE_W = be_width(DATA_W);

  owner_t owner_q;
  owner_t owner_d;
  logic   starve_at_max;

  toast_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk    (Clk),
    .reset  (Reset),
    .inc    (I_req & ~I_gnt),
    .clr    (I_gnt | ~I_req),
    .at_max (starve_at_max)
  );

  // Priority select: data wins unless fetch has been starved long enough; nothing during reset.
  always_comb begin
    I_gnt = 1'b0;
    D_gnt = 1'b0;
    if (!Reset) begin
      if (D_req && !(I_req && starve_at_max)) begin
        D_gnt = 1'b1;
      end else if (I_req) begin
        I_gnt = 1'b1;
      end
    end
  end

  // Memory command mux driven by whichever port holds the grant; idle bus is all zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (D_gnt) begin
      mem_en    = 1'b1;
      mem_we    = D_we ? D_be : {BE_W{1'b0}};
      mem_addr  = D_addr;
      mem_wdata = D_wdata;
    end else if (I_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = I_addr;
    end
  end

  // Next owner: only granted reads produce a response (writes, even with zero byte enables, do not).
  always_comb begin
    owner_d = OWN_NONE;
    if (I_gnt) begin
      owner_d = OWN_I;
    end else if (D_gnt && !D_we) begin
      owner_d = OWN_D;
    end
  end

  // Owner register; reset discards any read granted just before reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Both ports see the read bus; rvalid qualifies it. Reset masks a stale owner.
  assign I_rvalid   = ~Reset & (owner_q == OWN_I);
  assign D_rvalid   = ~Reset & (owner_q == OWN_D);
  assign I_rdata    = mem_rdata;
  assign D_rdata    = mem_rdata;
  assign Core_stall = ~Reset & ((I_req & ~I_gnt) | (D_req & ~D_gnt));

endmodule

// File: doc/toast_mem_arbiter.md
# toast_mem_arbiter

Arbiter sharing one single-port synchronous memory between the core's instruction-fetch port and its data load/store port. Sits between the core's fetch/MEM stages and the unified memory macro. Fixed data-over-fetch priority with a bounded fetch-starvation override. Tracks the single outstanding read and routes its response to the port that issued it.

## Interface
- ADDR_W, 32, address width for both ports and memory
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_MAX, 4, consecutive denied fetch-request cycles before fetch is forced to win; legal range 1..15
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- I_req  in  1  fetch request; held until I_gnt
- I_addr  in  ADDR_W  fetch address
- I_gnt  out  1  fetch request accepted this cycle (combinational)
- I_rvalid  out  1  fetch read data valid on I_rdata
- I_rdata  out  DATA_W  fetch read data
- D_req  in  1  data request; held until D_gnt
- D_we  in  1  1 = write, 0 = read
- D_be  in  DATA_W/8  write byte enables
- D_addr  in  ADDR_W  data address
- D_wdata  in  DATA_W  write data
- D_gnt  out  1  data request accepted this cycle (combinational)
- D_rvalid  out  1  data read data valid on D_rdata
- D_rdata  out  DATA_W  data read data
- mem_en  out  1  memory access this cycle
- mem_we  out  DATA_W/8  memory byte write enables; zero for reads
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read with mem_en=1
- Core_stall  out  1  (I_req & ~I_gnt) | (D_req & ~D_gnt)

## Operation
- Exactly one grant per cycle at most; I_gnt and D_gnt never both 1.
- Arbitration when both request: D wins, unless starve count == STARVE_MAX, then I wins.
- Single requester always granted in the same cycle.
- Granted port drives mem_addr/mem_we/mem_wdata; mem_en = I_gnt | D_gnt. Fetch grants drive mem_we = 0, mem_wdata = 0. No grant: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- D write with D_be = 0 is still granted; mem_en = 1, mem_we = 0; no rvalid.
- Owner register (OWN_NONE/OWN_I/OWN_D), next value: OWN_I on I_gnt, OWN_D on D_gnt & ~D_we, else OWN_NONE.
- I_rvalid = (owner == OWN_I); D_rvalid = (owner == OWN_D); I_rdata = D_rdata = mem_rdata (both ports see the bus; rvalid qualifies).
- A new grant may issue in the same cycle a response returns (full throughput, back-to-back reads).
- Starve counter: increments (saturating at STARVE_MAX) each cycle I_req & ~I_gnt; clears when I_gnt or ~I_req.
- Requesters must hold req/address/data stable until gnt; arbiter does not latch ungranted requests.

## Timing
- Grant latency: 0 cycles (combinational on req and starve count).
- Read latency: rvalid exactly 1 cycle after the granting cycle.
- Write completes in the granting cycle; no response.
- Worst-case fetch wait under continuous D_req: STARVE_MAX cycles, then granted on cycle STARVE_MAX+1.
- Reset: owner = OWN_NONE, starve count = 0. During Reset all outputs 0 (I_gnt, D_gnt, mem_en, mem_we, mem_addr, mem_wdata, rvalids, Core_stall forced 0). Read granted in the cycle before Reset asserts produces no rvalid.
- First cycle after Reset deasserts: normal arbitration, no pending response.

## Structure
- Package toast_arb_pkg: owner_t enum {OWN_NONE, OWN_I, OWN_D}; localparam BE_W = DATA_W/8 helper function.
- One sub-module: toast_arb_starve_ctr (saturating counter, inputs inc/clr, output at_max).
- Top holds priority mux, owner register, response routing.

## Test plan
- Reset: assert Reset with I_req=D_req=1 → all outputs 0; release → D_gnt=1 same cycle.
- Fetch only: I_req=1, I_addr=0x100 → I_gnt=1, mem_addr=0x100, mem_we=0; next cycle I_rvalid=1, I_rdata=mem_rdata.
- Contention, STARVE_MAX=4: I_req and D_req held high, D reads 0x200.. → D granted cycles 0-3, I granted cycle 4, D cycle 5; Core_stall=1 every cycle.
- Store: D_we=1, D_be=0b0011, D_wdata=0xDEADBEEF, D_addr=0x40 → mem_we=0b0011, mem_wdata=0xDEADBEEF; no D_rvalid next cycle.
- Back-to-back: D read 0x10 then fetch 0x14 consecutive cycles → D_rvalid cycle 1, I_rvalid cycle 2, never both high.
- Reset mid-read: D read granted cycle n, Reset cycle n+1 → D_rvalid stays 0.
